ex: RTL and testbench
=====================

EX -- requirements
Module: ex

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-003 SHALL have `aluop_i`, input, 8 bits: operation code from decode.
REQ-004 SHALL have `alusel_i`, input, 3 bits: result class, 000 NOP / 001 LOGIC / 010 SHIFT / 100 ARITH.
REQ-005 SHALL have `reg1_i`, input, 32 bits: operand 1; shift amount in bits [4:0] for shifts; dividend for divides.
REQ-006 SHALL have `reg2_i`, input, 32 bits: operand 2; value shifted for shifts; divisor for divides.
REQ-007 SHALL have `wd_i`, input, 5 bits: destination register address.
REQ-008 SHALL have `wreg_i`, input, 1 bit: destination write enable.
REQ-009 SHALL have `flush_i`, input, 1 bit: discard the current operation.
REQ-010 SHALL have `wd_o`, output, 5 bits: registered destination address.
REQ-011 SHALL have `wreg_o`, output, 1 bit: registered write enable.
REQ-012 SHALL have `wdata_o`, output, 32 bits: registered result.
REQ-013 SHALL have `whilo_o`, output, 1 bit: registered HI/LO write enable.
REQ-014 SHALL have `hi_o` and `lo_o`, outputs, 32 bits each: registered divide remainder (hi_o) and quotient (lo_o).
REQ-015 SHALL have `stall_req_o`, output, 1 bit: request to hold upstream stages.

Function
REQ-016 Opcodes SHALL be: OR 0x25, AND 0x24, XOR 0x26, NOR 0x27, ADDU 0x21, SUBU 0x23, SLT 0x2A, SLL 0x7C, SRL 0x02, SRA 0x03, DIV 0x1A, DIVU 0x1B.
REQ-017 A non-divide op SHALL be captured into wd_o/wreg_o/wdata_o at the next rising edge, with 1-cycle latency and whilo_o=0.
REQ-018 ADDU/SUBU SHALL wrap modulo 2^32; SLT SHALL be a signed compare giving 1 or 0.
REQ-019 Shifts SHALL use reg1_i[4:0]; SRA SHALL sign-fill.
REQ-020 alusel_i=000, or any unlisted opcode, SHALL give wdata_o=0 with wd_o/wreg_o passed through.
REQ-021 The divider FSM SHALL have states IDLE, BUSY and DONE.
REQ-022 IDLE SHALL go to BUSY on DIV/DIVU with a nonzero divisor, and SHALL go directly to DONE on a zero divisor.
REQ-023 BUSY SHALL run 32 restoring-division iterations on magnitudes, one per cycle, counter 0..31, then go to DONE.
REQ-024 DONE SHALL register hi_o/lo_o, set whilo_o=1 and wreg_o=0 for one cycle, then return to IDLE.
REQ-025 DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend; DIVU SHALL be unsigned.
REQ-026 A zero divisor SHALL give hi_o=lo_o=0.
REQ-027 stall_req_o SHALL be combinational: high in IDLE with a divide op presented, and high throughout BUSY; low in DONE.
REQ-028 Divide stall length SHALL be 33 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-029 Upstream SHALL hold inputs stable while stall_req_o=1; while stall_req_o=1 the block SHALL load all-zero outputs, so no duplicate writeback occurs.
REQ-030 flush_i=1 SHALL force the FSM to IDLE and load all outputs to zero at the next edge, with priority over every other event including DONE.

Reset
REQ-031 rst=0 SHALL immediately clear wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, the iteration counter and the divider datapath, and SHALL set the FSM to IDLE.
REQ-032 stall_req_o SHALL be 0 while reset is asserted.
REQ-033 Reset asserted mid-divide SHALL abandon the divide with no HI/LO write.

Configuration
REQ-034 Macro EX_DIV_EN SHALL control the divider.
REQ-035 With EX_DIV_EN defined, the divider FSM SHALL be compiled in.
REQ-036 Without EX_DIV_EN, DIV/DIVU SHALL behave as unlisted opcodes (REQ-020), stall_req_o SHALL be tied 0, whilo_o/hi_o/lo_o SHALL be tied 0, and no divider state SHALL exist.

Verification
REQ-037 OR, reg1=0x0000F0F0, reg2=0x00000F0F, wd=5, wreg=1 -> next cycle wdata_o=0x0000FFFF, wd_o=5, wreg_o=1.
REQ-038 ADDU 0xFFFFFFFF+0x00000001 -> wdata_o=0x00000000; SRA reg1=4, reg2=0x80000000 -> wdata_o=0xF8000000.
REQ-039 DIV reg1=0xFFFFFFF9 (-7), reg2=2 -> stall_req_o high 33 cycles, then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1 for one cycle.
REQ-040 DIVU with reg2=0 -> stall_req_o high 1 cycle, then hi_o=lo_o=0, whilo_o=1.
REQ-041 DIVU 100/7 with flush_i pulsed at iteration 10 -> FSM IDLE, no whilo_o pulse, stall_req_o low next cycle.
REQ-042 rst=0 at iteration 20 of a divide -> all outputs 0 immediately; after release, an OR op completes normally.

Source files
------------

// File: rtl/ex_if.sv
// ex_if: decode-to-execute bus plus the execute stage's registered results.
// The master modport is the upstream (decode) side; the slave modport is the
// execute stage itself.
interface ex_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_req_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stall_req_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stall_req_o
  );
endinterface

// File: rtl/ex.sv
// ex: execute stage. Logic/shift/arithmetic ops complete in one cycle.
// Optional multi-cycle restoring divider (DIV/DIVU) is compiled in when the
// macro EX_DIV_EN is defined; without it DIV/DIVU behave as unknown opcodes.
module ex (
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;

  logic [31:0] alu_result;

  // Single-cycle result; NOP class and unknown opcodes yield zero.
  always_comb begin
    alu_result = 32'h0000_0000;
    if (bus.alusel_i == 3'b000) begin
      alu_result = 32'h0000_0000;
    end else begin
      case (bus.aluop_i)
        OP_OR:   alu_result = bus.reg1_i | bus.reg2_i;
        OP_AND:  alu_result = bus.reg1_i & bus.reg2_i;
        OP_XOR:  alu_result = bus.reg1_i ^ bus.reg2_i;
        OP_NOR:  alu_result = ~(bus.reg1_i | bus.reg2_i);
        OP_ADDU: alu_result = bus.reg1_i + bus.reg2_i;
        OP_SUBU: alu_result = bus.reg1_i - bus.reg2_i;
        OP_SLT:  alu_result = ($signed(bus.reg1_i) < $signed(bus.reg2_i)) ? 32'h0000_0001 : 32'h0000_0000;
        OP_SLL:  alu_result = bus.reg2_i << bus.reg1_i[4:0];
        OP_SRL:  alu_result = bus.reg2_i >> bus.reg1_i[4:0];
        OP_SRA:  alu_result = $unsigned($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
        default: alu_result = 32'h0000_0000;
      endcase
    end
  end

`ifdef EX_DIV_EN

  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] dvsr;
  logic        neg_quot;
  logic        neg_rem;

  logic        div_op;
  logic        div_signed;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Divide decode, operand magnitudes, one restoring step and sign fix-up.
  always_comb begin
    div_op       = (bus.alusel_i != 3'b000) &&
                   ((bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU));
    div_signed   = (bus.aluop_i == OP_DIV);
    dividend_mag = (div_signed && bus.reg1_i[31]) ? (32'h0000_0000 - bus.reg1_i) : bus.reg1_i;
    divisor_mag  = (div_signed && bus.reg2_i[31]) ? (32'h0000_0000 - bus.reg2_i) : bus.reg2_i;
    shifted      = {rem, quot[31]};
    fits         = (shifted >= {1'b0, dvsr});
    if (fits) begin
      rem_next  = shifted[31:0] - dvsr;
      quot_next = {quot[30:0], 1'b1};
    end else begin
      rem_next  = shifted[31:0];
      quot_next = {quot[30:0], 1'b0};
    end
    quot_fix = neg_quot ? (32'h0000_0000 - quot) : quot;
    rem_fix  = neg_rem  ? (32'h0000_0000 - rem)  : rem;
  end

  // Stall while a divide is being accepted or iterating; never in reset.
  assign bus.stall_req_o = rst && (((state == IDLE) && div_op) || (state == BUSY));

  // Divider FSM and all registered stage outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      rem         <= 32'h0000_0000;
      quot        <= 32'h0000_0000;
      dvsr        <= 32'h0000_0000;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      bus.wd_o    <= 5'd0;
      bus.wreg_o  <= 1'b0;
      bus.wdata_o <= 32'h0000_0000;
      bus.whilo_o <= 1'b0;
      bus.hi_o    <= 32'h0000_0000;
      bus.lo_o    <= 32'h0000_0000;
    end else if (bus.flush_i) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      bus.wd_o    <= 5'd0;
      bus.wreg_o  <= 1'b0;
      bus.wdata_o <= 32'h0000_0000;
      bus.whilo_o <= 1'b0;
      bus.hi_o    <= 32'h0000_0000;
      bus.lo_o    <= 32'h0000_0000;
    end else begin
      // Default: no HI/LO write this cycle.
      bus.whilo_o <= 1'b0;
      bus.hi_o    <= 32'h0000_0000;
      bus.lo_o    <= 32'h0000_0000;
      case (state)
        IDLE: begin
          if (div_op) begin
            bus.wd_o    <= 5'd0;
            bus.wreg_o  <= 1'b0;
            bus.wdata_o <= 32'h0000_0000;
            cnt         <= 5'd0;
            rem         <= 32'h0000_0000;
            if (bus.reg2_i == 32'h0000_0000) begin
              // Zero divisor: skip iterations, report zero results.
              quot     <= 32'h0000_0000;
              dvsr     <= 32'h0000_0000;
              neg_quot <= 1'b0;
              neg_rem  <= 1'b0;
              state    <= DONE;
            end else begin
              quot     <= dividend_mag;
              dvsr     <= divisor_mag;
              neg_quot <= div_signed && (bus.reg1_i[31] ^ bus.reg2_i[31]);
              neg_rem  <= div_signed && bus.reg1_i[31];
              state    <= BUSY;
            end
          end else begin
            bus.wd_o    <= bus.wd_i;
            bus.wreg_o  <= bus.wreg_i;
            bus.wdata_o <= alu_result;
          end
        end
        BUSY: begin
          bus.wd_o    <= 5'd0;
          bus.wreg_o  <= 1'b0;
          bus.wdata_o <= 32'h0000_0000;
          rem         <= rem_next;
          quot        <= quot_next;
          cnt         <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          bus.wd_o    <= 5'd0;
          bus.wreg_o  <= 1'b0;
          bus.wdata_o <= 32'h0000_0000;
          bus.whilo_o <= 1'b1;
          bus.hi_o    <= rem_fix;
          bus.lo_o    <= quot_fix;
          state       <= IDLE;
        end
        default: begin
          bus.wd_o    <= 5'd0;
          bus.wreg_o  <= 1'b0;
          bus.wdata_o <= 32'h0000_0000;
          state       <= IDLE;
        end
      endcase
    end
  end

`else

  assign bus.stall_req_o = 1'b0;
  assign bus.whilo_o     = 1'b0;
  assign bus.hi_o        = 32'h0000_0000;
  assign bus.lo_o        = 32'h0000_0000;

  // Registered single-cycle result; flush discards the operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wd_o    <= 5'd0;
      bus.wreg_o  <= 1'b0;
      bus.wdata_o <= 32'h0000_0000;
    end else if (bus.flush_i) begin
      bus.wd_o    <= 5'd0;
      bus.wreg_o  <= 1'b0;
      bus.wdata_o <= 32'h0000_0000;
    end else begin
      bus.wd_o    <= bus.wd_i;
      bus.wreg_o  <= bus.wreg_i;
      bus.wdata_o <= alu_result;
    end
  end

`endif

endmodule

// File: tb/tb_ex.sv
// tb_ex: directed-vector bench for the execute stage. Divide scenarios are
// exercised when EX_DIV_EN is defined; otherwise DIV/DIVU are checked to act
// as unknown opcodes.
module tb_ex;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ex_if bus ();

  ex dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
  endtask

  // Present an op, clock once, sample 1 time unit after the edge.
  task automatic step_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    drive(op, sel, r1, r2, wd, wreg);
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp);
    step_op(op, sel, r1, r2, 5'd9, 1'b1);
    check(tag, bus.wdata_o, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef EX_DIV_EN
  // Run a divide to completion: count stall cycles, then check the HI/LO pulse.
  task automatic div_vec(input string tag, input logic [7:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stall_cycles;
    int guard;
    stall_cycles = 0;
    guard = 0;
    drive(op, 3'b100, r1, r2, 5'd3, 1'b1);
    #1;
    while (bus.stall_req_o === 1'b1 && guard < 100) begin
      stall_cycles = stall_cycles + 1;
      guard = guard + 1;
      tick();
    end
    check({tag, "_stall_len"}, stall_cycles, exp_stall);
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    check({tag, "_whilo_pre"}, {31'd0, bus.whilo_o}, 32'd0);
    tick();
    check({tag, "_whilo"}, {31'd0, bus.whilo_o}, 32'd1);
    check({tag, "_hi"}, bus.hi_o, exp_hi);
    check({tag, "_lo"}, bus.lo_o, exp_lo);
    check({tag, "_wreg"}, {31'd0, bus.wreg_o}, 32'd0);
    tick();
    check({tag, "_whilo_off"}, {31'd0, bus.whilo_o}, 32'd0);
  endtask
`endif

  initial begin
    int pulses;
    n_cmp = 0;
    n_err = 0;
    clk = 1'b0;
    rst = 1'b0;
    bus.flush_i = 1'b0;
    drive(8'h1B, 3'b100, 32'd100, 32'd7, 5'd1, 1'b1);
    #3;
    // Reset state, with a divide op presented.
    check("rst_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("rst_wdata", bus.wdata_o, 32'h0);
    check("rst_wreg", {31'd0, bus.wreg_o}, 32'd0);
    check("rst_wd", {27'd0, bus.wd_o}, 32'd0);
    check("rst_whilo", {31'd0, bus.whilo_o}, 32'd0);
    check("rst_hilo", bus.hi_o | bus.lo_o, 32'h0);
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single-cycle ops.
    step_op(8'h25, 3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
    check("or_wdata", bus.wdata_o, 32'h0000_FFFF);
    check("or_wd", {27'd0, bus.wd_o}, 32'd5);
    check("or_wreg", {31'd0, bus.wreg_o}, 32'd1);
    check("or_whilo", {31'd0, bus.whilo_o}, 32'd0);
    alu_vec("and",  8'h24, 3'b001, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    alu_vec("xor",  8'h26, 3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_vec("nor",  8'h27, 3'b001, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0);
    alu_vec("addu_wrap", 8'h21, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu_vec("subu_wrap", 8'h23, 3'b100, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE);
    alu_vec("slt_neg",   8'h2A, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu_vec("slt_false", 8'h2A, 3'b100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000);
    alu_vec("slt_signed",8'h2A, 3'b100, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000);
    alu_vec("sll",       8'h7C, 3'b010, 32'h0000_0004, 32'h0000_000F, 32'h0000_00F0);
    alu_vec("sll_31",    8'h7C, 3'b010, 32'h0000_001F, 32'h0000_0001, 32'h8000_0000);
    alu_vec("sll_mask",  8'h7C, 3'b010, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010);
    alu_vec("srl",       8'h02, 3'b010, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000);
    alu_vec("sra_neg",   8'h03, 3'b010, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000);
    alu_vec("sra_pos",   8'h03, 3'b010, 32'h0000_0004, 32'h7000_0000, 32'h0700_0000);

    // NOP class and unlisted opcode: zero result, wd/wreg passed through.
    step_op(8'h25, 3'b000, 32'h1234_5678, 32'h1111_1111, 5'd17, 1'b1);
    check("nop_wdata", bus.wdata_o, 32'h0);
    check("nop_wd", {27'd0, bus.wd_o}, 32'd17);
    check("nop_wreg", {31'd0, bus.wreg_o}, 32'd1);
    alu_vec("unlisted", 8'h55, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    // Flush discards a single-cycle op.
    bus.flush_i = 1'b1;
    step_op(8'h25, 3'b001, 32'hFFFF_0000, 32'h0000_FFFF, 5'd6, 1'b1);
    bus.flush_i = 1'b0;
    check("flush_wdata", bus.wdata_o, 32'h0);
    check("flush_wd", {27'd0, bus.wd_o}, 32'd0);
    check("flush_wreg", {31'd0, bus.wreg_o}, 32'd0);

`ifdef EX_DIV_EN
    div_vec("div_m7_2",  8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    div_vec("div_7_m2",  8'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    div_vec("divu_100_7",8'h1B, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    div_vec("divu_big",  8'h1B, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0000_000F, 32'h0FFF_FFFF);
    div_vec("divu_zero", 8'h1B, 32'd100, 32'd0, 1, 32'd0, 32'd0);

    // Flush at iteration 10 abandons the divide.
    drive(8'h1B, 3'b100, 32'd100, 32'd7, 5'd3, 1'b1);
    tick();
    repeat (10) tick();
    check("fl_stall_busy", {31'd0, bus.stall_req_o}, 32'd1);
    bus.flush_i = 1'b1;
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    bus.flush_i = 1'b0;
    check("fl_stall_low", {31'd0, bus.stall_req_o}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.whilo_o === 1'b1) pulses = pulses + 1;
      tick();
    end
    check("fl_no_whilo", pulses, 0);

    // Reset at iteration 20 abandons the divide immediately.
    drive(8'h1B, 3'b100, 32'd100, 32'd7, 5'd3, 1'b1);
    tick();
    repeat (20) tick();
    rst = 1'b0;
    #1;
    check("rs_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("rs_whilo", {31'd0, bus.whilo_o}, 32'd0);
    check("rs_hilo", bus.hi_o | bus.lo_o, 32'h0);
    check("rs_wdata", bus.wdata_o, 32'h0);
    drive(8'h25, 3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd7, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    check("rs_or_stall", {31'd0, bus.stall_req_o}, 32'd0);
    tick();
    check("rs_or_wdata", bus.wdata_o, 32'h0000_00FF);
    check("rs_or_wd", {27'd0, bus.wd_o}, 32'd7);
    pulses = 0;
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (bus.whilo_o === 1'b1) pulses = pulses + 1;
      tick();
    end
    check("rs_no_whilo", pulses, 0);
`else
    // Divider absent: DIV/DIVU are unknown opcodes, no stall, no HI/LO.
    drive(8'h1A, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4, 1'b1);
    #1;
    check("nodiv_stall", {31'd0, bus.stall_req_o}, 32'd0);
    tick();
    check("nodiv_wdata", bus.wdata_o, 32'h0);
    check("nodiv_wd", {27'd0, bus.wd_o}, 32'd4);
    check("nodiv_wreg", {31'd0, bus.wreg_o}, 32'd1);
    check("nodiv_whilo", {31'd0, bus.whilo_o}, 32'd0);
    alu_vec("nodiv_divu", 8'h1B, 3'b100, 32'd100, 32'd7, 32'h0);
    // Reset mid-stream clears registered outputs immediately.
    step_op(8'h25, 3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_async_wdata", bus.wdata_o, 32'h0);
    check("rst_async_wd", {27'd0, bus.wd_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_after_or", bus.wdata_o, 32'h0000_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
